// File: rtl/delay_pipeline_pkg.sv
// Shared helpers for the delay_pipeline block.
// Holds the occupancy-counter width rule so ports and internals agree on it.
package delay_pipeline_pkg;

   // A counter that must reach CYCLES needs $clog2(CYCLES+1) bits.
   // It is never narrower than 1 bit, so a port still exists when CYCLES <= 1.
   function automatic int count_width(input int cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/delay_stage.sv
// One pipeline register: a data word with its valid tag in the top bit.
// Synchronous active-low reset and synchronous clear both load RESET_VALUE; en gates the load.
module delay_stage #(
   parameter int               WIDTH       = 9,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // NOTE: registered state is written with <= so that every stage samples its
   // neighbour's pre-edge value and the chain shifts instead of collapsing.
   always_ff @(posedge clk) begin
      if (!rst || i_clear) begin
         r_q <= RESET_VALUE;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/delay_pipeline.sv
// CYCLES-deep delay line with stall, valid tagging, synchronous flush and an occupancy count.
// CYCLES == 0 degenerates to a combinational wire with a constant-zero count.
module delay_pipeline
   import delay_pipeline_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               CYCLES      = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            flush,
   input  logic [WIDTH-1:0]                in,
   input  logic                            valid_in,
   output logic [WIDTH-1:0]                out,
   output logic                            valid_out,
   output logic [count_width(CYCLES)-1:0]  count
);

   localparam int CW = count_width(CYCLES);

   generate
      if (CYCLES == 0) begin : g_bypass
         assign out       = in;
         assign valid_out = valid_in;
         assign count     = '0;
      end else begin : g_pipe
         logic [WIDTH:0]  w_stage_q [CYCLES];
         logic [CW-1:0]   r_count;
         logic [CW-1:0]   w_count_next;

         for (genvar k = 0; k < CYCLES; k++) begin : g_stage
            logic [WIDTH:0] w_d;

            if (k == 0) begin : g_first
               assign w_d = {valid_in, in};
            end else begin : g_next
               assign w_d = w_stage_q[k-1];
            end

            delay_stage #(
               .WIDTH       (WIDTH + 1),
               .RESET_VALUE ({1'b0, RESET_VALUE})
            ) u_stage (
               .clk     (clk),
               .rst     (rst),
               .i_en    (en),
               .i_clear (flush),
               .i_d     (w_d),
               .o_q     (w_stage_q[k])
            );
         end

         // Incremental occupancy: one word enters and the last one leaves per shift.
         assign w_count_next = r_count + CW'(valid_in) - CW'(valid_out);

         always_ff @(posedge clk) begin
            if (!rst || flush) begin
               r_count <= '0;
            end else if (en) begin
               r_count <= w_count_next;
            end
         end

         assign out       = w_stage_q[CYCLES-1][WIDTH-1:0];
         assign valid_out = w_stage_q[CYCLES-1][WIDTH];
         assign count     = r_count;
      end
   endgenerate

endmodule

// File: tb/tb_delay_pipeline.sv
// Directed bench for delay_pipeline (CYCLES = 4, RESET_VALUE = 8'hA5) plus a CYCLES = 0 instance.
// Expected values are hand-derived tables, closed-form sequences and a small bit-counting model.
module tb_delay_pipeline;

   localparam logic [7:0] RV = 8'hA5;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       flush;
   logic [7:0] din;
   logic       vin;
   logic [7:0] dout;
   logic       vout;
   logic [2:0] cnt;

   logic [7:0] z_in;
   logic       z_vin;
   logic [7:0] z_out;
   logic       z_vout;
   logic [0:0] z_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Mixed-valid stream after a flush: in = 8'h10 + i, edges e1..e15.
   int vin_tab  [15] = '{0,0,1,1,0,1,1,1,1,1,0,0,0,0,0};
   int vout_tab [15] = '{0,0,0,0,0,1,1,0,1,1,1,1,1,0,0};
   int cnt_tab  [15] = '{0,0,1,2,2,3,3,3,4,4,3,2,1,0,0};

   logic [7:0] m_d [4];
   logic       m_v [4];
   int         m_cnt;

   always #5 clk = ~clk;

   delay_pipeline #(
      .WIDTH       (8),
      .CYCLES      (4),
      .RESET_VALUE (RV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .in        (din),
      .valid_in  (vin),
      .out       (dout),
      .valid_out (vout),
      .count     (cnt)
   );

   delay_pipeline #(
      .WIDTH       (8),
      .CYCLES      (0),
      .RESET_VALUE (RV)
   ) dut_zero (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .in        (z_in),
      .valid_in  (z_vin),
      .out       (z_out),
      .valid_out (z_vout),
      .count     (z_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [7:0] e_out, input logic e_v, input int e_cnt);
      check({tag, ".out"}, 32'(dout), 32'(e_out));
      check({tag, ".valid_out"}, 32'(vout), 32'(e_v));
      check({tag, ".count"}, 32'(cnt), 32'(e_cnt));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; en = 1'b1; flush = 1'b0; din = 8'hFF; vin = 1'b1;
      z_in = 8'h00; z_vin = 1'b0;

      // Reset held for five edges with live input.
      for (int i = 0; i < 5; i++) begin
         tick();
         check_all($sformatf("reset%0d", i), RV, 1'b0, 0);
      end

      // Latency ramp: in = k on edge k; out = k-3 once four shifts have happened.
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         din = 8'(k); vin = 1'b1;
         tick();
         check_all($sformatf("ramp%0d", k), (k >= 4) ? 8'(k - 3) : RV, k >= 4, (k < 4) ? k : 4);
      end

      // Stall: three edges with en low must freeze everything.
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din = 8'h99 + 8'(i);
         tick();
         check_all($sformatf("stall%0d", i), 8'd5, 1'b1, 4);
      end

      // Resume: no word lost or repeated across the stall.
      en = 1'b1;
      for (int k = 9; k <= 12; k++) begin
         din = 8'(k);
         tick();
         check_all($sformatf("resume%0d", k), 8'(k - 3), 1'b1, 4);
      end

      // Flush while full, with en low and a valid word offered.
      flush = 1'b1; en = 1'b0; din = 8'h77; vin = 1'b1;
      tick();
      check_all("flush", RV, 1'b0, 0);
      flush = 1'b0; en = 1'b1;

      // Mixed valid pattern: invalid data still shifts; full and empty boundaries.
      for (int i = 0; i < 15; i++) begin
         din = 8'h10 + 8'(i); vin = vin_tab[i][0];
         tick();
         check_all($sformatf("mix%0d", i + 1), (i >= 3) ? 8'h10 + 8'(i - 3) : RV,
                   vout_tab[i][0], cnt_tab[i]);
      end

      // Reset mid-stream, then the first word takes the full latency.
      din = 8'h50; vin = 1'b1;
      tick();
      din = 8'h51;
      tick();
      rst = 1'b0;
      tick();
      check_all("midrst", RV, 1'b0, 0);
      rst = 1'b1; din = 8'h42; vin = 1'b1;
      tick();
      check_all("post1", RV, 1'b0, 1);
      din = 8'h00; vin = 1'b0;
      tick();
      check_all("post2", RV, 1'b0, 1);
      tick();
      check_all("post3", RV, 1'b0, 1);
      tick();
      check_all("post4", 8'h42, 1'b1, 1);
      tick();
      check_all("post5", 8'h00, 1'b0, 0);

      // Random traffic against a bit-counting reference.
      for (int k = 0; k < 4; k++) begin
         m_d[k] = RV; m_v[k] = 1'b0;
      end
      for (int c = 0; c < 2000; c++) begin
         rst   = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
         en    = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 49) == 0);
         din   = 8'($urandom);
         vin   = 1'($urandom_range(0, 1));
         tick();
         if (!rst || flush) begin
            for (int k = 0; k < 4; k++) begin
               m_d[k] = RV; m_v[k] = 1'b0;
            end
         end else if (en) begin
            for (int k = 3; k > 0; k--) begin
               m_d[k] = m_d[k-1]; m_v[k] = m_v[k-1];
            end
            m_d[0] = din; m_v[0] = vin;
         end
         m_cnt = 0;
         for (int k = 0; k < 4; k++) m_cnt += int'(m_v[k]);
         check_all($sformatf("rnd%0d", c), m_d[3], m_v[3], m_cnt);
         check($sformatf("rnd%0d.bound", c), 32'(cnt <= 3'd4), 32'd1);
      end

      // CYCLES == 0: combinational pass-through, count tied to zero.
      rst = 1'b1; en = 1'b1; flush = 1'b0;
      for (int i = 0; i < 20; i++) begin
         z_in  = 8'($urandom);
         z_vin = 1'($urandom_range(0, 1));
         #2;
         check($sformatf("zero%0d.out", i), 32'(z_out), 32'(z_in));
         check($sformatf("zero%0d.valid_out", i), 32'(z_vout), 32'(z_vin));
         check($sformatf("zero%0d.count", i), 32'(z_cnt), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
